// File: rtl/hja_step_ctrl.sv
// rtl/hja_step_ctrl.sv - step button debounce and run/step/burst/halt pipeline advance control
module hja_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic [15:0]      sw,
    output logic             run_en,
    output logic             busy,
    output logic             btn_level,
    output logic [CNT_W-1:0] step_count
);

    typedef enum logic [1:0] {IDLE, RUN, BURST, HALT} state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] mode;
    logic [7:0] burst_n;
    logic       unused_sw;

    assign mode      = sw[15:14];
    assign burst_n   = sw[7:0];
    assign unused_sw = ^sw[13:8];

    logic             sync0_q, sync1_q;
    logic [CNT_W-1:0] db_cnt_q;
    logic             btn_level_q, btn_level_dly_q, press_q;
    state_t           state_q;
    logic [7:0]       burst_q;
    logic             run_en_q, busy_q;
    logic [CNT_W-1:0] step_q, step_d;

    // Two-flop synchroniser, then a level is accepted only after it holds DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0_q         <= 1'b0;
            sync1_q         <= 1'b0;
            db_cnt_q        <= '0;
            btn_level_q     <= 1'b0;
            btn_level_dly_q <= 1'b0;
            press_q         <= 1'b0;
        end else begin
            sync0_q         <= btn_raw;
            sync1_q         <= sync0_q;
            btn_level_dly_q <= btn_level_q;
            press_q         <= btn_level_q & ~btn_level_dly_q;
            if (sync1_q == btn_level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                db_cnt_q    <= '0;
                btn_level_q <= sync1_q;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    // Outputs are decided with the next state so run_en/busy are plain flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            burst_q  <= '0;
            run_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            run_en_q <= 1'b0;
            busy_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    case (mode)
                        2'b00: begin
                            state_q  <= RUN;
                            run_en_q <= 1'b1;
                        end
                        2'b01: run_en_q <= press_q;
                        2'b10: begin
                            if (press_q && burst_n != 8'd0) begin
                                burst_q  <= burst_n;
                                state_q  <= BURST;
                                run_en_q <= 1'b1;
                                busy_q   <= 1'b1;
                            end
                        end
                        default: state_q <= HALT;
                    endcase
                end
                RUN: begin
                    if (mode == 2'b00) begin
                        run_en_q <= 1'b1;
                    end else begin
                        state_q <= (mode == 2'b11) ? HALT : IDLE;
                    end
                end
                BURST: begin
                    burst_q <= burst_q - 1'b1;
                    if (mode == 2'b11) begin
                        state_q <= HALT;
                        burst_q <= '0;
                    end else if (burst_q == 8'd1) begin
                        state_q <= IDLE;
                    end else begin
                        run_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                HALT: begin
                    if (mode != 2'b11) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign step_d = step_q + {{(CNT_W-1){1'b0}}, run_en_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) step_q <= '0;
        else      step_q <= step_d;
    end

    assign run_en     = run_en_q;
    assign busy       = busy_q;
    assign btn_level  = btn_level_q;
    assign step_count = step_q;

endmodule

// File: tb/tb_hja_step_ctrl.sv
// tb/tb_hja_step_ctrl.sv - self-checking bench for hja_step_ctrl
module tb_hja_step_ctrl;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_raw = 1'b0;
    logic [15:0] sw = 16'h0000;
    logic        run_en, busy, btn_level;
    logic [15:0] step_count;

    int tests = 0;
    int fails = 0;

    int run_cnt = 0, start_cnt = 0, busy_cnt = 0;
    logic run_prev = 1'b0;

    hja_step_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw(sw),
        .run_en(run_en), .busy(busy), .btn_level(btn_level), .step_count(step_count)
    );

    always #5 clk = ~clk;

    // Observed activity: pulses, rising edges of run_en and busy cycles.
    always @(posedge clk) begin
        if (run_en) run_cnt++;
        if (run_en && !run_prev) start_cnt++;
        if (busy) busy_cnt++;
        run_prev = run_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the button long enough to be accepted, then release and let the release settle.
    task automatic press();
        btn_raw = 1'b1;
        cyc(DB + 4);
        btn_raw = 1'b0;
        cyc(DB + 4);
    endtask

    int exp_steps;
    int r0, s0, b0, n, k;
    logic ok;

    initial begin
        // 1: reset state, then a single step
        sw = 16'h4000;
        cyc(2);
        chk("reset_run_en", {31'd0, run_en}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_btn_level", {31'd0, btn_level}, 0);
        chk("reset_step_count", {16'd0, step_count}, 0);
        rst = 1'b1;
        exp_steps = 0;
        cyc(2);
        r0 = run_cnt;
        btn_raw = 1'b1;
        cyc(2 + DB - 1);
        chk("step_level_early", {31'd0, btn_level}, 0);
        cyc(1);
        chk("step_level_rise", {31'd0, btn_level}, 1);
        cyc(20 - (2 + DB));
        btn_raw = 1'b0;
        cyc(DB + 6);
        exp_steps += 1;
        chk("step_pulses", run_cnt - r0, 1);
        chk("step_count_1", {16'd0, step_count}, exp_steps);
        chk("step_level_release", {31'd0, btn_level}, 0);

        // 2: glitches shorter than the debounce window, fixed then random lengths
        r0 = run_cnt;
        ok = 1'b1;
        for (int g = 1; g <= 6; g++) begin
            btn_raw = 1'b1;
            cyc(g <= 3 ? g : $urandom_range(1, DB - 1));
            btn_raw = 1'b0;
            for (int c = 0; c < DB + 4; c++) begin
                @(negedge clk);
                if (btn_level !== 1'b0) ok = 1'b0;
            end
        end
        chk("glitch_level", {31'd0, ok}, 1);
        chk("glitch_pulses", run_cnt - r0, 0);
        chk("glitch_step_count", {16'd0, step_count}, exp_steps);

        // 3: bursts of fixed and random length, then N=0
        for (int t = 0; t < 4; t++) begin
            n = (t == 0) ? 5 : $urandom_range(1, 40);
            sw = 16'h8000 | 16'(n);
            r0 = run_cnt; s0 = start_cnt; b0 = busy_cnt;
            press();
            cyc(n + 10);
            exp_steps += n;
            chk("burst_pulses", run_cnt - r0, n);
            chk("burst_contiguous", start_cnt - s0, 1);
            chk("burst_busy", busy_cnt - b0, n);
            chk("burst_step_count", {16'd0, step_count}, exp_steps);
        end
        sw = 16'h8000;
        r0 = run_cnt;
        press();
        cyc(10);
        chk("burst_zero", run_cnt - r0, 0);

        // 4: long burst aborted by HALT, then back to RUN
        sw = 16'h80C8;
        btn_raw = 1'b1;
        k = 0;
        for (int c = 0; c < 400 && k < 10; c++) begin
            @(negedge clk);
            if (run_en) k++;
        end
        chk("abort_reached_10", k, 10);
        sw = 16'hC000;
        cyc(1);
        exp_steps += 10;
        chk("abort_run_en", {31'd0, run_en}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_step_count", {16'd0, step_count}, exp_steps);
        btn_raw = 1'b0;
        cyc(DB + 6);
        chk("halt_hold", {31'd0, run_en}, 0);
        sw = 16'h0000;
        cyc(1);
        chk("halt_to_idle", {31'd0, run_en}, 0);
        cyc(1);
        chk("run_start", {31'd0, run_en}, 1);
        cyc(8);
        sw = 16'h4000;
        cyc(3);
        exp_steps += 9;
        chk("run_stop", {31'd0, run_en}, 0);
        chk("run_step_count", {16'd0, step_count}, exp_steps);

        // 5: free run across the counter wrap
        rst = 1'b0;
        sw = 16'h0000;
        cyc(2);
        rst = 1'b1;
        cyc(65535);
        chk("wrap_pre", {16'd0, step_count}, 32'hFFFE);
        cyc(3);
        chk("wrap_post", {16'd0, step_count}, 32'h0001);

        // 6: asynchronous reset in the middle of a burst
        sw = 16'h4000;
        cyc(3);
        sw = 16'h8064;
        btn_raw = 1'b1;
        k = 0;
        for (int c = 0; c < 200 && k < 7; c++) begin
            @(negedge clk);
            if (run_en) k++;
        end
        chk("mid_burst_reached", k, 7);
        chk("mid_burst_busy", {31'd0, busy}, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_run_en", {31'd0, run_en}, 0);
        chk("async_busy", {31'd0, busy}, 0);
        chk("async_btn_level", {31'd0, btn_level}, 0);
        chk("async_step_count", {16'd0, step_count}, 0);
        btn_raw = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
